// File: rtl/fifo_stream_pkg.sv
// Shared sizing helpers and types for the FIFO read-side stream logic.
package fifo_stream_pkg;

  // Largest supported output buffer; occ_t is sized to cover it.
  localparam int unsigned MaxBufDepth = 8;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef logic [occ_width(MaxBufDepth)-1:0] occ_t;

endpackage

// File: rtl/rd_out_buffer.sv
// Small circular output buffer: register array with head/tail indices and an occupancy count.
module rd_out_buffer
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DataLen  = 16,
  parameter int unsigned BufDepth = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               push_i,
  input  logic [DataLen-1:0] push_data_i,
  input  logic               pop_i,
  output logic [DataLen-1:0] data_o,
  output occ_t               occ_o
);

  localparam int unsigned IdxW    = idx_width(BufDepth);
  localparam int unsigned LastIdx = BufDepth - 1;

  logic [DataLen-1:0] mem_q [BufDepth];
  logic [IdxW-1:0]    head_q, head_d;
  logic [IdxW-1:0]    tail_q, tail_d;
  occ_t               occ_q, occ_d;
  logic               do_pop;

  // Indices wrap at BufDepth-1, which need not be a power of two.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(LastIdx)) ? '0 : idx + IdxW'(1);
  endfunction

  assign do_pop = pop_i && (occ_q != '0);

  // Next-state for indices and occupancy; a push and pop together leave occ unchanged.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push_i) begin
      tail_d = wrap_inc(tail_q);
    end
    if (do_pop) begin
      head_d = wrap_inc(head_q);
    end
    if (push_i && !do_pop) begin
      occ_d = occ_q + occ_t'(1);
    end else if (!push_i && do_pop) begin
      occ_d = occ_q - occ_t'(1);
    end
  end

  // Buffer storage and pointer registers, cleared on synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < BufDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
      end
    end
  end

  assign data_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/async_fifo_reader.sv
// Read-domain adapter: turns the FIFO's one-cycle-latency read port into a registered
// valid/ready stream, using credits (occ + in-flight) so backpressure never drops a word.
// BUF_DEPTH must be within 2..8; 3 or more sustains one word per cycle.
module async_fifo_reader
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 16,
  parameter int unsigned BUF_DEPTH = 3,
  parameter int unsigned CNT_LEN   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_LEN-1:0] fifo_data,
  input  logic                fifo_rd_empty,
  output logic                fifo_rd_en,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_LEN-1:0]  drain_cnt,
  output logic                busy
);

  occ_t               occ;
  logic               pending_q;
  logic [CNT_LEN-1:0] drain_cnt_q, drain_cnt_d;
  logic               pop;

  rd_out_buffer #(
    .DataLen  (DATA_LEN),
    .BufDepth (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .push_i      (pending_q),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .data_o      (out_data),
    .occ_o       (occ)
  );

  // Issue and stream control; reads depend on registered credit only, never on out_ready.
  always_comb begin
    fifo_rd_en  = reset_n && !fifo_rd_empty && ((occ + occ_t'(pending_q)) < occ_t'(BUF_DEPTH));
    out_valid   = (occ != '0);
    pop         = out_valid && out_ready;
    busy        = out_valid || pending_q;
    drain_cnt_d = pop ? drain_cnt_q + CNT_LEN'(1) : drain_cnt_q;
  end

  // In-flight read flag and delivered-word counter (wraps naturally).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      pending_q   <= fifo_rd_en;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign drain_cnt = drain_cnt_q;

endmodule
